trigger_monitor: RTL and testbench

- Receive side of the periodic scan-trigger interface. Monitors one external trigger line, which is a periodic active-high pulse.
- Synchronises the line into clk8m and rejects glitches.
- Measures pulse period and high width in clk8m cycles and compares the period against the expected programmed value.
- Flags lost triggers. Used for loopback self-check of trigger outputs and for qualifying externally supplied triggers.

---
 rtl/trigger_monitor.sv | 172 +++++++++++++++++
 tb/tb_trigger_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/trigger_monitor.sv
// Receive-side monitor for the periodic scan-trigger line: synchronises and deglitches it,
// then measures period and high width in clk8m cycles and flags period errors and lost triggers.
module trigger_monitor #(
   parameter logic [15:0] MIN_WIDTH = 16'd4,
   parameter logic [15:0] TOL       = 16'd2,
   parameter logic [15:0] TIMEOUT   = 16'hFFF0
) (
   input  logic        i_clk8m,
   input  logic        i_rst_n,
   input  logic        i_line_in,
   input  logic [15:0] i_exp_period,
   output logic [15:0] o_period_out,
   output logic [15:0] o_width_out,
   output logic        o_meas_valid,
   output logic        o_period_valid,
   output logic        o_period_err,
   output logic        o_trig_lost,
   output logic [15:0] o_pulse_cnt,
   output logic [7:0]  o_glitch_cnt
);

   typedef enum logic {
      S_WAIT = 1'b0,
      S_HIGH = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic        r_sync1;
   logic        r_line_s;
   logic        r_line_d;
   logic        w_rise;
   logic        w_fall;

   logic [15:0] r_per_cnt;
   logic [15:0] r_cand_cnt;
   logic [15:0] r_wid_cnt;
   logic [15:0] r_cand_per;
   logic        r_have_ref;

   logic        w_capture;
   logic        w_accept;
   logic        w_glitch;
   logic        w_timeout;

   logic [16:0] w_exp_full;
   logic [16:0] w_diff;
   logic        w_out_of_tol;

   function automatic logic [15:0] satInc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

   always_ff @(posedge i_clk8m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1  <= 1'b0;
         r_line_s <= 1'b0;
         r_line_d <= 1'b0;
      end else begin
         r_sync1  <= i_line_in;
         r_line_s <= r_sync1;
         r_line_d <= r_line_s;
      end
   end

   assign w_rise = r_line_s & ~r_line_d;
   assign w_fall = ~r_line_s & r_line_d;

   always_ff @(posedge i_clk8m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_WAIT;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_WAIT:  if (w_rise) w_next_state = S_HIGH;
         S_HIGH:  if (w_fall) w_next_state = S_WAIT;
         default: w_next_state = S_WAIT;
      endcase
   end

   // A rise in the same cycle as an expired timeout takes precedence over the timeout.
   always_comb begin
      w_capture = 1'b0;
      w_accept  = 1'b0;
      w_glitch  = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         S_WAIT: begin
            w_capture = w_rise;
            w_timeout = ~w_rise && (r_per_cnt >= TIMEOUT);
         end
         S_HIGH: begin
            w_accept = w_fall && (r_wid_cnt >= MIN_WIDTH);
            w_glitch = w_fall && (r_wid_cnt < MIN_WIDTH);
         end
         default: begin
            w_capture = 1'b0;
         end
      endcase
   end

   assign w_exp_full   = {1'b0, i_exp_period} + 17'd1;
   assign w_diff       = ({1'b0, r_cand_per} >= w_exp_full) ? ({1'b0, r_cand_per} - w_exp_full)
                                                             : (w_exp_full - {1'b0, r_cand_per});
   assign w_out_of_tol = w_diff > {1'b0, TOL};

   // per_cnt already holds cycles since the accepted rise, so it is the candidate period as-is.
   always_ff @(posedge i_clk8m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_per_cnt  <= '0;
         r_cand_cnt <= '0;
         r_wid_cnt  <= '0;
         r_cand_per <= '0;
      end else begin
         if (w_accept) begin
            r_per_cnt <= satInc(r_cand_cnt);
         end else if (w_timeout) begin
            r_per_cnt <= '0;
         end else begin
            r_per_cnt <= satInc(r_per_cnt);
         end
         if (w_capture) begin
            r_cand_per <= r_per_cnt;
            r_cand_cnt <= 16'd1;
            r_wid_cnt  <= 16'd1;
         end else if (r_state == S_HIGH) begin
            r_cand_cnt <= satInc(r_cand_cnt);
            r_wid_cnt  <= satInc(r_wid_cnt);
         end
      end
   end

   always_ff @(posedge i_clk8m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_period_out   <= '0;
         o_width_out    <= '0;
         o_meas_valid   <= 1'b0;
         o_period_valid <= 1'b0;
         o_period_err   <= 1'b0;
         o_trig_lost    <= 1'b0;
         o_pulse_cnt    <= '0;
         o_glitch_cnt   <= '0;
         r_have_ref     <= 1'b0;
      end else begin
         o_meas_valid   <= w_accept;
         o_period_valid <= w_accept && r_have_ref;
         if (w_accept) begin
            o_width_out <= r_wid_cnt;
            o_pulse_cnt <= o_pulse_cnt + 16'd1;
            o_trig_lost <= 1'b0;
            r_have_ref  <= 1'b1;
            if (r_have_ref) begin
               o_period_out <= r_cand_per;
               o_period_err <= w_out_of_tol;
            end
         end else if (w_timeout) begin
            o_trig_lost <= 1'b1;
            r_have_ref  <= 1'b0;
         end
         if (w_glitch && (o_glitch_cnt != 8'hFF)) begin
            o_glitch_cnt <= o_glitch_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_trigger_monitor.sv
// Directed bench for trigger_monitor: drives pulse trains, pushes expected measurements
// into a scoreboard at each rising drive and checks them whenever meas_valid strobes.
module tb_trigger_monitor;

   localparam logic [15:0] TIMEOUT_TB = 16'd4080;
   localparam int          MIN_W      = 4;

   logic        clock;
   logic        rstN;
   logic        lineIn;
   logic [15:0] expPeriod;
   logic [15:0] periodOut;
   logic [15:0] widthOut;
   logic        measValid;
   logic        periodValid;
   logic        periodErr;
   logic        trigLost;
   logic [15:0] pulseCnt;
   logic [7:0]  glitchCnt;

   typedef struct {
      int   width;
      logic pValid;
      int   period;
      logic perr;
      int   pulseCnt;
      int   glitchCnt;
   } item_t;

   item_t       sb[$];
   item_t       monItem;

   int          compared   = 0;
   int          mismatched = 0;
   int          cyc        = 0;
   int          lastRise   = 0;
   int          target     = 0;

   logic        haveRefModel = 1'b0;
   logic [15:0] pulseModel   = '0;
   int          glitchModel  = 0;
   int          periodModel  = 0;
   logic        errModel     = 1'b0;

   trigger_monitor #(.TIMEOUT(TIMEOUT_TB)) dut (
      .i_clk8m        (clock),
      .i_rst_n        (rstN),
      .i_line_in      (lineIn),
      .i_exp_period   (expPeriod),
      .o_period_out   (periodOut),
      .o_width_out    (widthOut),
      .o_meas_valid   (measValid),
      .o_period_valid (periodValid),
      .o_period_err   (periodErr),
      .o_trig_lost    (trigLost),
      .o_pulse_cnt    (pulseCnt),
      .o_glitch_cnt   (glitchCnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".periodOut"}, 32'(periodOut), 32'd0);
      checkOutput({tag, ".widthOut"}, 32'(widthOut), 32'd0);
      checkOutput({tag, ".measValid"}, 32'(measValid), 32'd0);
      checkOutput({tag, ".periodValid"}, 32'(periodValid), 32'd0);
      checkOutput({tag, ".periodErr"}, 32'(periodErr), 32'd0);
      checkOutput({tag, ".trigLost"}, 32'(trigLost), 32'd0);
      checkOutput({tag, ".pulseCnt"}, 32'(pulseCnt), 32'd0);
      checkOutput({tag, ".glitchCnt"}, 32'(glitchCnt), 32'd0);
   endtask

   task automatic resetModel();
      haveRefModel = 1'b0;
      pulseModel   = '0;
      glitchModel  = 0;
      periodModel  = 0;
      errModel     = 1'b0;
   endtask

   // Called on a negedge: one pulse of highCycles, then lowCycles low; the model decides accept/glitch.
   task automatic applyStimulus(input int highCycles, input int lowCycles);
      item_t item;
      int    diff;
      lineIn = 1'b1;
      if (highCycles >= MIN_W) begin
         pulseModel  = pulseModel + 16'd1;
         item.pValid = haveRefModel;
         if (haveRefModel) begin
            periodModel = cyc - lastRise;
            diff        = periodModel - (int'(expPeriod) + 1);
            if (diff < 0) diff = -diff;
            errModel    = (diff > 2);
         end
         item.width     = highCycles;
         item.period    = periodModel;
         item.perr      = errModel;
         item.pulseCnt  = int'(pulseModel);
         item.glitchCnt = glitchModel;
         haveRefModel   = 1'b1;
         lastRise       = cyc;
         sb.push_back(item);
      end else if (glitchModel < 255) begin
         glitchModel++;
      end
      repeat (highCycles) @(negedge clock);
      lineIn = 1'b0;
      repeat (lowCycles) @(negedge clock);
   endtask

   // Scoreboard consumer: every meas_valid strobe must match the oldest expected measurement.
   always @(negedge clock) begin
      if (periodValid && !measValid) begin
         checkOutput("periodValidAlone", 32'(periodValid), 32'd0);
      end
      if (measValid) begin
         checkOutput("measExpected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         if (sb.size() > 0) begin
            monItem = sb.pop_front();
            checkOutput("widthOut", 32'(widthOut), 32'(monItem.width));
            checkOutput("periodValid", 32'(periodValid), 32'(monItem.pValid));
            checkOutput("periodOut", 32'(periodOut), 32'(monItem.period));
            checkOutput("periodErr", 32'(periodErr), 32'(monItem.perr));
            checkOutput("pulseCnt", 32'(pulseCnt), 32'(monItem.pulseCnt));
            checkOutput("glitchCnt", 32'(glitchCnt), 32'(monItem.glitchCnt));
            checkOutput("trigLostOnMeas", 32'(trigLost), 32'd0);
         end
      end
   end

   initial begin
      rstN      = 1'b0;
      lineIn    = 1'b0;
      expPeriod = 16'd1000;
      repeat (3) @(negedge clock);
      checkAllZero("reset");
      rstN = 1'b1;
      @(negedge clock);

      repeat (3) applyStimulus(51, 950);
      checkOutput("trainPulseCnt", 32'(pulseCnt), 32'(pulseModel));
      checkOutput("trainErr", 32'(periodErr), 32'd0);

      expPeriod = 16'd995;
      repeat (2) applyStimulus(51, 950);
      checkOutput("errHeldHigh", 32'(periodErr), 32'd1);
      expPeriod = 16'd999;
      applyStimulus(51, 950);
      checkOutput("errCleared", 32'(periodErr), 32'd0);
      expPeriod = 16'd1000;

      applyStimulus(51, 249);
      applyStimulus(2, 699);
      checkOutput("glitchCount", 32'(glitchCnt), 32'(glitchModel));
      applyStimulus(51, 950);
      checkOutput("periodAfterGlitch", 32'(periodOut), 32'd1001);

      applyStimulus(51, 950);
      applyStimulus(51, 20);
      target = lastRise + 2 + int'(TIMEOUT_TB);
      while (cyc < target) @(negedge clock);
      checkOutput("trigLostBefore", 32'(trigLost), 32'd0);
      @(negedge clock);
      checkOutput("trigLostAt", 32'(trigLost), 32'd1);
      haveRefModel = 1'b0;
      repeat (10) @(negedge clock);
      checkOutput("trigLostHeld", 32'(trigLost), 32'd1);
      applyStimulus(51, 950);
      checkOutput("trigLostCleared", 32'(trigLost), 32'd0);
      applyStimulus(51, 950);

      applyStimulus(51, 950);
      lineIn = 1'b1;
      repeat (20) @(negedge clock);
      rstN = 1'b0;
      #1;
      checkAllZero("midPulseReset");
      resetModel();
      repeat (31) @(negedge clock);
      lineIn = 1'b0;
      repeat (20) @(negedge clock);
      rstN = 1'b1;
      repeat (2) applyStimulus(51, 950);
      checkOutput("pulseCntAfterReset", 32'(pulseCnt), 32'd2);

      rstN = 1'b0;
      resetModel();
      repeat (2) @(negedge clock);
      rstN = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 320; i++) applyStimulus(3, 5);
      checkOutput("glitchSaturated", 32'(glitchCnt), 32'd255);
      checkOutput("pulseCntZero", 32'(pulseCnt), 32'(pulseModel));
      checkOutput("measIdle", 32'(measValid), 32'd0);

      repeat (10) @(negedge clock);
      checkOutput("sbDrained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
